// File: rtl/phase_attention_4n.sv
// Four integrate-and-fire neurons framed by a shared 256-step phase counter;
// pairwise phase distances become relevance/coincidence, and the best pair is selected.
module pa_neuron #(
  parameter logic [7:0] THRESHOLD = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gphase,
  input  logic [7:0] cur,
  output logic [7:0] phase,
  output logic       fired
);
  logic [7:0] membrane;
  logic [8:0] m;

  assign m = {1'b0, membrane} + {1'b0, cur};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      membrane <= '0;
      phase    <= 8'hFF;
      fired    <= 1'b0;
    end else if (gphase == 8'hFF) begin
      membrane <= '0;
      phase    <= 8'hFF;
      fired    <= 1'b0;
    end else if (!fired) begin
      if (m >= {1'b0, THRESHOLD}) begin
        fired    <= 1'b1;
        phase    <= gphase + 8'd1;
        membrane <= '0;
      end else begin
        // m < THRESHOLD <= 255 here, so the upper bit is zero
        membrane <= m[7:0];
      end
    end
  end
endmodule

module phase_attention_4n #(
  parameter logic [7:0] THRESHOLD = 8'd200,
  parameter logic [7:0] PHASE_TOL = 8'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cur_a,
  input  logic [7:0] cur_b,
  input  logic [7:0] cur_c,
  input  logic [7:0] cur_d,
  output logic [7:0] phase_a,
  output logic [7:0] phase_b,
  output logic [7:0] phase_c,
  output logic [7:0] phase_d,
  output logic       fired_a,
  output logic       fired_b,
  output logic       fired_c,
  output logic       fired_d,
  output logic [7:0] rel_ab,
  output logic [7:0] rel_ac,
  output logic [7:0] rel_ad,
  output logic [7:0] rel_bc,
  output logic [7:0] rel_bd,
  output logic [7:0] rel_cd,
  output logic       coin_ab,
  output logic       coin_ac,
  output logic       coin_ad,
  output logic       coin_bc,
  output logic       coin_bd,
  output logic       coin_cd,
  output logic [2:0] winner,
  output logic [7:0] winner_rel
);
  localparam int NUM_N = 4;
  localparam int NUM_P = 6;

  logic [7:0]             gphase;
  logic [NUM_N-1:0][7:0]  cur;
  logic [NUM_N-1:0][7:0]  phase;
  logic [NUM_N-1:0]       fired;
  logic [NUM_P-1:0][7:0]  rel_c, rel_q;
  logic [NUM_P-1:0]       coin_c, coin_q;
  logic [2:0]             win_c;
  logic [7:0]             wrel_c;

  assign cur = {cur_d, cur_c, cur_b, cur_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gphase <= '0;
    else        gphase <= gphase + 8'd1;
  end

  for (genvar n = 0; n < NUM_N; n++) begin : g_neuron
    pa_neuron #(.THRESHOLD(THRESHOLD)) u_neuron (
      .clk   (clk),
      .rst_n (rst_n),
      .gphase(gphase),
      .cur   (cur[n]),
      .phase (phase[n]),
      .fired (fired[n])
    );
  end

  // Pair p maps to (PX,PY) in order AB,AC,AD,BC,BD,CD
  for (genvar p = 0; p < NUM_P; p++) begin : g_pair
    localparam int PX = (p < 3) ? 0 : (p < 5) ? 1 : 2;
    localparam int PY = (p < 3) ? p + 1 : (p < 5) ? p - 1 : 3;
    logic [7:0] d;
    logic [9:0] d4, r10;

    assign d   = (phase[PX] >= phase[PY]) ? phase[PX] - phase[PY] : phase[PY] - phase[PX];
    assign d4  = {d, 2'b00};
    assign r10 = 10'd255 - d4;

    always_comb begin
      rel_c[p]  = '0;
      coin_c[p] = 1'b0;
      if (fired[PX] && fired[PY]) begin
        rel_c[p]  = (d4 > 10'd255) ? 8'd0 : r10[7:0];
        coin_c[p] = (d <= PHASE_TOL);
      end
    end
  end

  always_comb begin
    win_c  = '0;
    wrel_c = rel_c[0];
    for (int i = 1; i < NUM_P; i++) begin
      if (rel_c[i] > wrel_c) begin
        wrel_c = rel_c[i];
        win_c  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q      <= '0;
      coin_q     <= '0;
      winner     <= '0;
      winner_rel <= '0;
    end else begin
      rel_q      <= rel_c;
      coin_q     <= coin_c;
      winner     <= win_c;
      winner_rel <= wrel_c;
    end
  end

  assign {phase_d, phase_c, phase_b, phase_a} = phase;
  assign {fired_d, fired_c, fired_b, fired_a} = fired;
  assign {rel_cd, rel_bd, rel_bc, rel_ad, rel_ac, rel_ab} = rel_q;
  assign {coin_cd, coin_bd, coin_bc, coin_ad, coin_ac, coin_ab} = coin_q;
endmodule

// File: tb/tb_phase_attention_4n.sv
// Scoreboard bench: expected cycle results derived from ceil(THRESHOLD/cur) per scenario.
module tb_phase_attention_4n;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0][7:0] cur;
  logic [3:0][7:0] ph_o;
  logic [3:0]      fi_o;
  logic [5:0][7:0] rel_o;
  logic [5:0]      coin_o;
  logic [2:0]      win_o;
  logic [7:0]      wrel_o;

  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic [3:0][7:0] ph;
    logic [3:0]      fi;
    logic [5:0][7:0] rel;
    logic [5:0]      coin;
    logic [2:0]      win;
    logic [7:0]      wrel;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  phase_attention_4n dut (
    .clk(clk), .rst_n(rst_n),
    .cur_a(cur[0]), .cur_b(cur[1]), .cur_c(cur[2]), .cur_d(cur[3]),
    .phase_a(ph_o[0]), .phase_b(ph_o[1]), .phase_c(ph_o[2]), .phase_d(ph_o[3]),
    .fired_a(fi_o[0]), .fired_b(fi_o[1]), .fired_c(fi_o[2]), .fired_d(fi_o[3]),
    .rel_ab(rel_o[0]), .rel_ac(rel_o[1]), .rel_ad(rel_o[2]),
    .rel_bc(rel_o[3]), .rel_bd(rel_o[4]), .rel_cd(rel_o[5]),
    .coin_ab(coin_o[0]), .coin_ac(coin_o[1]), .coin_ad(coin_o[2]),
    .coin_bc(coin_o[3]), .coin_bd(coin_o[4]), .coin_cd(coin_o[5]),
    .winner(win_o), .winner_rel(wrel_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  function automatic exp_t model(input int ca, input int cb, input int cc, input int cd);
    exp_t e;
    int c[4];
    int ph[4];
    int px[6];
    int py[6];
    int d, r, best;
    c  = '{ca, cb, cc, cd};
    px = '{0, 0, 0, 1, 1, 2};
    py = '{1, 2, 3, 2, 3, 3};
    e = '0;
    for (int i = 0; i < 4; i++) begin
      ph[i]   = (c[i] == 0) ? 255 : (200 + c[i] - 1) / c[i];
      e.ph[i] = 8'(ph[i]);
      e.fi[i] = (c[i] != 0);
    end
    best = 0;
    for (int p = 0; p < 6; p++) begin
      if (e.fi[px[p]] && e.fi[py[p]]) begin
        d = ph[px[p]] - ph[py[p]];
        if (d < 0) d = -d;
        r = 255 - 4 * d;
        e.rel[p]  = 8'((r < 0) ? 0 : r);
        e.coin[p] = (d <= 15);
      end
      if (p == 0 || int'(e.rel[p]) > best) begin
        if (p == 0 || int'(e.rel[p]) > best) begin
          best = int'(e.rel[p]);
          if (p != 0) e.win = 3'(p);
        end
      end
    end
    e.wrel = 8'(best);
    return e;
  endfunction

  task automatic wait_g(input int g);
    int n = 0;
    @(negedge clk);
    while (int'(dut.gphase) != g && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk($sformatf("timeout_g%0d", g), int'(dut.gphase), g);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_phase%0d", tag, i), int'(ph_o[i]), int'(e.ph[i]));
      chk($sformatf("%s_fired%0d", tag, i), int'(fi_o[i]), int'(e.fi[i]));
    end
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("%s_rel%0d", tag, p), int'(rel_o[p]), int'(e.rel[p]));
      chk($sformatf("%s_coin%0d", tag, p), int'(coin_o[p]), int'(e.coin[p]));
    end
    chk({tag, "_winner"}, int'(win_o), int'(e.win));
    chk({tag, "_winner_rel"}, int'(wrel_o), int'(e.wrel));
  endtask

  task automatic start(input int a, input int b, input int c, input int d);
    @(negedge clk);
    rst_n = 1'b0;
    cur = {8'(d), 8'(c), 8'(b), 8'(a)};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scenario(input string tag, input int a, input int b, input int c, input int d);
    start(a, b, c, d);
    sb.push_back(model(a, b, c, d));
    wait_g(253);
    compare(tag);
  endtask

  initial begin
    exp_t zero_e;
    cur = '0;
    zero_e = '0;
    zero_e.ph = {4{8'hFF}};
    #12;
    // reset state
    sb.push_back(zero_e);
    compare("reset");
    chk("reset_gphase", int'(dut.gphase), 0);

    scenario("S1", 50, 48, 20, 5);
    // hand-derived anchors alongside the model
    chk("S1_anchor_rel_cd", int'(rel_o[5]), 135);
    chk("S1_anchor_win_rel", int'(wrel_o), 251);

    // next cycle: outputs drop after the boundary until re-fire
    sb.push_back(zero_e);
    wait_g(2);
    compare("S1_drop");
    sb.push_back(model(50, 48, 20, 5));
    wait_g(253);
    compare("S1_cyc2");

    scenario("S2", 10, 8, 50, 48);
    chk("S2_anchor_winner", int'(win_o), 5);
    scenario("S3", 30, 32, 28, 31);
    chk("S3_anchor_tie", int'(win_o), 0);
    chk("S3_anchor_rel255", int'(wrel_o), 255);
    scenario("S4", 50, 25, 12, 5);
    chk("S4_anchor_rel_ab", int'(rel_o[0]), 239);

    scenario("D0", 50, 48, 20, 0);
    sb.push_back(model(50, 48, 20, 0));
    wait_g(253);
    compare("D0_cyc2");

    // late fire: cur=1 fires at step 200
    scenario("LATE", 1, 200, 3, 4);

    // mid-cycle async reset
    start(50, 25, 12, 5);
    wait_g(100);
    rst_n = 1'b0;
    #1;
    sb.push_back(zero_e);
    compare("midrst");
    chk("midrst_gphase", int'(dut.gphase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(50, 25, 12, 5));
    wait_g(253);
    compare("midrst_after");

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
